// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
// Holds the FSM encoding, register-field widths and counter widths.
package hazard_pkg;

  localparam int REG_W   = 5;
  localparam int LCNT_W  = 2;
  localparam int MDCNT_W = 4;

  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic {
    RUN    = 1'b0,
    LSTALL = 1'b1
  } state_t;

  // True when an ID source field is actually read and names the given register.
  function automatic logic regMatch(input logic uses,
                                    input logic [REG_W-1:0] src,
                                    input logic [REG_W-1:0] dst);
    return uses && (src == dst);
  endfunction

endpackage

// File: rtl/md_busy_counter.sv
// Mult/div busy counter: reloads on every issue and otherwise counts down to zero.
// The result is valid again in the first cycle the counter reads zero.
module md_busy_counter
  import hazard_pkg::*;
#(
  parameter int unsigned MD_LATENCY = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic issue,
  output logic md_busy
);

  logic [MDCNT_W-1:0] r_mdcnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mdcnt <= '0;
    end else if (issue) begin
      r_mdcnt <= MDCNT_W'(MD_LATENCY);
    end else if (r_mdcnt != '0) begin
      r_mdcnt <= r_mdcnt - MDCNT_W'(1);
    end
  end

  assign md_busy = (r_mdcnt != '0);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Hazard and stall controller for the 5-stage core: load-use, HI/LO-while-busy
// and taken-branch handling, driving PC freeze and IF/ID, ID/EX hold/flush.
module hazard_stall_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned MD_LATENCY        = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             id_is_muldiv,
  input  logic             id_reads_hilo,
  input  logic             ex_branch_taken,
  output logic             pc_freeze,
  output logic             ifid_freeze,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             md_busy
);

  // The first stall cycle is the hit itself, so LSTALL covers the remaining ones.
  localparam logic              EXTEND    = (LOAD_STALL_CYCLES > 1);
  localparam logic [LCNT_W-1:0] LCNT_INIT =
    (LOAD_STALL_CYCLES > 1) ? LCNT_W'(LOAD_STALL_CYCLES - 2) : '0;

  state_t            r_state;
  state_t            w_nextState;
  logic [LCNT_W-1:0] r_lcnt;
  logic [LCNT_W-1:0] w_nextLcnt;

  logic w_luHit;
  logic w_mdHit;
  logic w_stall;
  logic w_issue;
  logic w_mdBusy;

  assign w_luHit = ex_mem_read && (ex_rd != REG_ZERO) &&
                   (regMatch(id_uses_rs, id_rs, ex_rd) ||
                    regMatch(id_uses_rt, id_rt, ex_rd));

  assign w_mdHit = w_mdBusy && (id_reads_hilo || id_is_muldiv);

  assign w_stall = (w_luHit || w_mdHit || (r_state == LSTALL)) && !ex_branch_taken;

  assign w_issue = id_is_muldiv && !w_stall && !ex_branch_taken;

  md_busy_counter #(
    .MD_LATENCY(MD_LATENCY)
  ) u_mdCounter (
    .clk    (clk),
    .rst    (rst),
    .issue  (w_issue),
    .md_busy(w_mdBusy)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RUN;
      r_lcnt  <= '0;
    end else begin
      r_state <= w_nextState;
      r_lcnt  <= w_nextLcnt;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_nextLcnt  = r_lcnt;
    case (r_state)
      RUN: begin
        if (w_luHit && !ex_branch_taken && EXTEND) begin
          w_nextState = LSTALL;
          w_nextLcnt  = LCNT_INIT;
        end
      end
      LSTALL: begin
        // A taken branch makes the held ID instruction wrong-path, so drop the stall.
        if (ex_branch_taken) begin
          w_nextState = RUN;
          w_nextLcnt  = '0;
        end else if (r_lcnt == '0) begin
          w_nextState = RUN;
        end else begin
          w_nextLcnt = r_lcnt - LCNT_W'(1);
        end
      end
      default: begin
        w_nextState = RUN;
        w_nextLcnt  = '0;
      end
    endcase
  end

  always_comb begin
    pc_freeze   = 1'b0;
    ifid_freeze = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    md_busy     = 1'b0;
    if (!rst) begin
      md_busy = w_mdBusy;
      if (w_stall) begin
        pc_freeze   = 1'b1;
        ifid_freeze = 1'b1;
        idex_flush  = 1'b1;
      end else if (ex_branch_taken) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench: three controllers (1, 2 and 3 load-stall cycles) share
// stimulus; a queue of expected outputs is checked each cycle, plus a PC model.
module tb_hazard_stall_ctrl;

  // Output vector order: {pc_freeze, ifid_freeze, ifid_flush, idex_flush, md_busy}
  localparam logic [4:0] Z  = 5'b00000;
  localparam logic [4:0] S  = 5'b11010;
  localparam logic [4:0] B  = 5'b00110;
  localparam logic [4:0] SB = 5'b11011;
  localparam logic [4:0] ZB = 5'b00001;
  localparam logic [4:0] BB = 5'b00111;
  localparam logic [31:0] PC_BASE = 32'h1010_1010;

  typedef struct packed {
    logic [4:0] d1;
    logic [4:0] d2;
    logic [4:0] d3;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] idRs, idRt, exRd;
  logic       idUsesRs, idUsesRt, exMemRead, idIsMuldiv, idReadsHilo, exBranchTaken;
  logic [4:0] out1, out2, out3;

  logic [31:0] pcIn  = 32'h0;
  logic [31:0] pcReg = 32'h0;
  logic [31:0] expPc = 32'h0;

  exp_t sbQ[$];
  int   checks   = 0;
  int   errors   = 0;
  int   cycleIdx = 0;

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.LOAD_STALL_CYCLES(1), .MD_LATENCY(4)) dut1 (
    .clk(clk), .rst(rst), .id_rs(idRs), .id_rt(idRt), .id_uses_rs(idUsesRs),
    .id_uses_rt(idUsesRt), .ex_mem_read(exMemRead), .ex_rd(exRd),
    .id_is_muldiv(idIsMuldiv), .id_reads_hilo(idReadsHilo), .ex_branch_taken(exBranchTaken),
    .pc_freeze(out1[4]), .ifid_freeze(out1[3]), .ifid_flush(out1[2]),
    .idex_flush(out1[1]), .md_busy(out1[0]));

  hazard_stall_ctrl #(.LOAD_STALL_CYCLES(2), .MD_LATENCY(4)) dut2 (
    .clk(clk), .rst(rst), .id_rs(idRs), .id_rt(idRt), .id_uses_rs(idUsesRs),
    .id_uses_rt(idUsesRt), .ex_mem_read(exMemRead), .ex_rd(exRd),
    .id_is_muldiv(idIsMuldiv), .id_reads_hilo(idReadsHilo), .ex_branch_taken(exBranchTaken),
    .pc_freeze(out2[4]), .ifid_freeze(out2[3]), .ifid_flush(out2[2]),
    .idex_flush(out2[1]), .md_busy(out2[0]));

  hazard_stall_ctrl #(.LOAD_STALL_CYCLES(3), .MD_LATENCY(4)) dut3 (
    .clk(clk), .rst(rst), .id_rs(idRs), .id_rt(idRt), .id_uses_rs(idUsesRs),
    .id_uses_rt(idUsesRt), .ex_mem_read(exMemRead), .ex_rd(exRd),
    .id_is_muldiv(idIsMuldiv), .id_reads_hilo(idReadsHilo), .ex_branch_taken(exBranchTaken),
    .pc_freeze(out3[4]), .ifid_freeze(out3[3]), .ifid_flush(out3[2]),
    .idex_flush(out3[1]), .md_busy(out3[0]));

  // PC register consumer of the 3-cycle controller's freeze.
  always_ff @(posedge clk) begin
    if (!out3[4]) pcReg <= pcIn;
  end

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s cycle %0d: got %h expected %h", tag, cycleIdx, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                               input logic ur, input logic ut, input logic mr,
                               input logic [4:0] rd, input logic md, input logic hl,
                               input logic br, input logic [4:0] e1, input logic [4:0] e2,
                               input logic [4:0] e3);
    exp_t e;
    rst = r; idRs = rs; idRt = rt; idUsesRs = ur; idUsesRt = ut;
    exMemRead = mr; exRd = rd; idIsMuldiv = md; idReadsHilo = hl; exBranchTaken = br;
    pcIn = PC_BASE + 32'(cycleIdx) * 32'd4;
    sbQ.push_back('{d1: e1, d2: e2, d3: e3});
    @(negedge clk);
    e = sbQ.pop_front();
    checkOutput("lsc1", {27'd0, out1}, {27'd0, e.d1});
    checkOutput("lsc2", {27'd0, out2}, {27'd0, e.d2});
    checkOutput("lsc3", {27'd0, out3}, {27'd0, e.d3});
    if (!e.d3[4]) expPc = pcIn;
    @(posedge clk);
    #1;
    checkOutput("pc", pcReg, expPc);
    cycleIdx++;
  endtask

  task automatic idle(input logic [4:0] e1, input logic [4:0] e2, input logic [4:0] e3);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, e1, e2, e3);
  endtask

  task automatic loadUse(input logic r, input logic hl, input logic br,
                         input logic [4:0] e1, input logic [4:0] e2, input logic [4:0] e3);
    applyStimulus(r, 5'd8, 5'd0, 1, 0, 1, 5'd8, 0, hl, br, e1, e2, e3);
  endtask

  task automatic hilo(input logic md, input logic hl, input logic br,
                      input logic [4:0] e1, input logic [4:0] e2, input logic [4:0] e3);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, md, hl, br, e1, e2, e3);
  endtask

  initial begin
    @(posedge clk);
    #1;
    // Reset state
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, Z, Z, Z);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, Z, Z, Z);
    idle(Z, Z, Z);

    // Load-use via rs: 1, 2 and 3 stall cycles respectively
    loadUse(0, 0, 0, S, S, S);
    idle(Z, S, S);
    idle(Z, Z, S);
    idle(Z, Z, Z);

    // r0 destination never stalls; unused rs never stalls
    applyStimulus(0, 5'd0, 5'd0, 1, 1, 1, 5'd0, 0, 0, 0, Z, Z, Z);
    applyStimulus(0, 5'd7, 5'd3, 0, 1, 1, 5'd7, 0, 0, 0, Z, Z, Z);

    // Load-use via rt
    applyStimulus(0, 5'd9, 5'd9, 0, 1, 1, 5'd9, 0, 0, 0, S, S, S);
    idle(Z, S, S);
    idle(Z, Z, S);
    idle(Z, Z, Z);

    // Branch wins over load-use; no residual stall
    loadUse(0, 0, 1, B, B, B);
    idle(Z, Z, Z);

    // Branch while in LSTALL releases it
    loadUse(0, 0, 0, S, S, S);
    hilo(0, 0, 1, B, B, B);
    idle(Z, Z, Z);

    // Mult/div issue then mfhi: busy and stalled for four cycles
    hilo(1, 0, 0, Z, Z, Z);
    for (int i = 0; i < 4; i++) hilo(0, 1, 0, SB, SB, SB);
    hilo(0, 1, 0, Z, Z, Z);

    // Load-use and HI/LO together, sources released independently
    hilo(1, 0, 0, Z, Z, Z);
    loadUse(0, 1, 0, SB, SB, SB);
    idle(ZB, SB, SB);
    idle(ZB, ZB, SB);
    idle(ZB, ZB, ZB);
    idle(Z, Z, Z);

    // Branch does not cancel an issued mult/div
    hilo(1, 0, 0, Z, Z, Z);
    hilo(0, 1, 1, BB, BB, BB);
    for (int i = 0; i < 3; i++) hilo(0, 1, 0, SB, SB, SB);
    hilo(0, 1, 0, Z, Z, Z);

    // Mult/div alongside a branch does not issue
    hilo(1, 0, 1, B, B, B);
    hilo(0, 1, 0, Z, Z, Z);

    // Reset in the 2nd cycle of a load stall, hazard inputs still present
    loadUse(0, 0, 0, S, S, S);
    loadUse(1, 0, 0, Z, Z, Z);
    idle(Z, Z, Z);

    // Reset while mult/div busy
    hilo(1, 0, 0, Z, Z, Z);
    hilo(0, 1, 0, SB, SB, SB);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, Z, Z, Z);
    hilo(0, 1, 0, Z, Z, Z);

    // PC integration over a 3-cycle load stall
    idle(Z, Z, Z);
    loadUse(0, 0, 0, S, S, S);
    idle(Z, S, S);
    idle(Z, Z, S);
    idle(Z, Z, Z);
    idle(Z, Z, Z);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
